// File: rtl/fact_seq_if.sv
// Bundle between fact_seq and the outside world.
// The master side drives start/n and hosts the shared 32-bit adder
// (add_s/add_co). The slave side is the sequencer itself.
interface fact_seq_if #(
   parameter int NW = 5
);
   logic          start;
   logic [NW-1:0] n;
   logic          busy;
   logic          done;
   logic [31:0]   result;
   logic          ovf;
   logic [31:0]   add_a;
   logic [31:0]   add_b;
   logic          add_ci;
   logic [31:0]   add_s;
   logic          add_co;

   modport master (
      output start, n, add_s, add_co,
      input  busy, done, result, ovf, add_a, add_b, add_ci
   );

   modport slave (
      input  start, n, add_s, add_co,
      output busy, done, result, ovf, add_a, add_b, add_ci
   );
endinterface

// File: rtl/fact_seq.sv
// Iterative factorial sequencer: n! by shift-and-add multiplication,
// sharing one external 32-bit adder for every partial-product addition.
// Optional build macro FACT_OVF_SAT_EN: when defined, an overflowed
// result is reported as 32'hFFFF_FFFF instead of n! mod 2^32.
module fact_seq #(
   parameter int NW = 5
) (
   input  logic       clk,
   input  logic       reset,
   fact_seq_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, LOAD, MUL, NEXT, DONE} state_t;

   localparam logic [NW-1:0] LAST_BIT = NW'(NW - 1);
   localparam logic [NW-1:0] ONE_N    = NW'(1);
   localparam logic [NW-1:0] TWO_N    = NW'(2);

   state_t        state;
   state_t        state_nx;
   logic [NW-1:0] nreg;
   logic [NW-1:0] k;
   logic [31:0]   acc;
   logic [31:0]   prod;
   logic [31:0]   mcand;
   logic [NW-1:0] mplr;
   logic [NW-1:0] bitcnt;
   logic          ovf_acc;
   logic [31:0]   result_q;
   logic          ovf_q;
   logic          done_q;
   logic [31:0]   final_val;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state decode; the adder only sees live operands during MUL
   always_comb begin
      state_nx  = state;
      bus.add_a = '0;
      bus.add_b = '0;
      case (state)
         IDLE: if (bus.start) state_nx = (bus.n <= ONE_N) ? DONE : LOAD;
         LOAD: state_nx = MUL;
         MUL: begin
            bus.add_a = prod;
            bus.add_b = mcand;
            if (bitcnt == LAST_BIT) state_nx = NEXT;
         end
         NEXT: state_nx = (k == nreg) ? DONE : LOAD;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Value latched into result at DONE, saturating when the build asks for it
   always_comb begin
`ifdef FACT_OVF_SAT_EN
      final_val = ovf_acc ? 32'hFFFF_FFFF : acc;
`else
      final_val = acc;
`endif
   end

   // Datapath: operand capture, shift-and-add step, sticky overflow, result hold
   always_ff @(posedge clk) begin
      if (reset) begin
         nreg     <= '0;
         k        <= '0;
         acc      <= '0;
         prod     <= '0;
         mcand    <= '0;
         mplr     <= '0;
         bitcnt   <= '0;
         ovf_acc  <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  nreg    <= bus.n;
                  acc     <= 32'd1;
                  k       <= TWO_N;
                  ovf_acc <= 1'b0;
               end
            end
            LOAD: begin
               prod   <= '0;
               mcand  <= acc;
               mplr   <= k;
               bitcnt <= '0;
            end
            MUL: begin
               if (mplr[0]) prod <= bus.add_s;
               ovf_acc <= ovf_acc
                        | (mplr[0] & bus.add_co)
                        | (mcand[31] & (|mplr[NW-1:1]));
               mcand  <= mcand << 1;
               mplr   <= mplr >> 1;
               bitcnt <= bitcnt + 1'b1;
            end
            NEXT: begin
               acc <= prod;
               if (k != nreg) k <= k + 1'b1;
            end
            DONE: begin
               result_q <= final_val;
               ovf_q    <= ovf_acc;
            end
            default: ;
         endcase
         done_q <= (state == DONE);
      end
   end

   assign bus.busy   = (state != IDLE);
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.ovf    = ovf_q;
   assign bus.add_ci = 1'b0;

endmodule

// File: tb/tb_fact_seq.sv
// Self-checking bench for fact_seq with a behavioural adder and a
// plain-arithmetic factorial reference model.
module tb_fact_seq;

   localparam int NW = 5;

   logic clk = 1'b0;
   logic reset;
   int   testsRun    = 0;
   int   testsFailed = 0;

   fact_seq_if #(.NW(NW)) bus ();

   fact_seq #(.NW(NW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Behavioural 32-bit adder shared with the sequencer
   assign {bus.add_co, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_ci};

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Reference: true product with a sticky flag once it leaves 32 bits
   function automatic void refFact(input int nv, output logic [31:0] r, output logic o);
      longint unsigned p;
      p = 1;
      o = 1'b0;
      for (int i = 2; i <= nv; i++) begin
         p = p * longint'(i);
         if ((p >> 32) != 0) o = 1'b1;
         p = p & 64'h0000_0000_FFFF_FFFF;
      end
`ifdef FACT_OVF_SAT_EN
      r = o ? 32'hFFFF_FFFF : p[31:0];
`else
      r = p[31:0];
`endif
   endfunction

   task automatic applyStimulus(input int nVal, input bit interfere, input int otherN);
      logic [31:0] expRes;
      logic        expOvf;
      int          lat;
      int          firstDone;
      int          pulses;
      int          busyErrs;
      int          addNz;
      int          ciErrs;
      refFact(nVal, expRes, expOvf);
      lat       = (nVal <= 1) ? 1 : 1 + (nVal - 1) * (NW + 2);
      firstDone = -1;
      pulses    = 0;
      busyErrs  = 0;
      addNz     = 0;
      ciErrs    = 0;
      bus.start = 1'b1;
      bus.n     = NW'(nVal);
      @(posedge clk);
      for (int c = 0; c <= lat + 3; c++) begin
         @(negedge clk);
         if (c == 0) begin
            bus.start = 1'b0;
            bus.n     = NW'($urandom);
         end
         if (interfere && c == 3) begin
            bus.start = 1'b1;
            bus.n     = NW'(otherN);
         end
         if (interfere && c == 4) bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            pulses++;
            if (firstDone < 0) firstDone = c;
         end
         if (bus.busy !== (c < lat)) busyErrs++;
         if (bus.add_a != 0 || bus.add_b != 0) addNz++;
         if (bus.add_ci !== 1'b0) ciErrs++;
      end
      checkOutput($sformatf("latency n=%0d", nVal), 64'(firstDone), 64'(lat));
      checkOutput($sformatf("pulses n=%0d", nVal), 64'(pulses), 64'd1);
      checkOutput($sformatf("result n=%0d", nVal), 64'(bus.result), 64'(expRes));
      checkOutput($sformatf("ovf n=%0d", nVal), 64'(bus.ovf), 64'(expOvf));
      checkOutput($sformatf("busy n=%0d", nVal), 64'(busyErrs), 64'd0);
      checkOutput($sformatf("add_ci n=%0d", nVal), 64'(ciErrs), 64'd0);
      if (nVal <= 1) checkOutput($sformatf("adder_idle n=%0d", nVal), 64'(addNz), 64'd0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.n     = '0;
      reset     = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset busy", 64'(bus.busy), 64'd0);
      checkOutput("reset done", 64'(bus.done), 64'd0);
      checkOutput("reset result", 64'(bus.result), 64'd0);
      checkOutput("reset ovf", 64'(bus.ovf), 64'd0);
      checkOutput("reset add_a", 64'(bus.add_a), 64'd0);
      checkOutput("reset add_b", 64'(bus.add_b), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      applyStimulus(5, 1'b0, 0);
      applyStimulus(0, 1'b0, 0);
      applyStimulus(1, 1'b0, 0);
      applyStimulus(12, 1'b0, 0);
      applyStimulus(13, 1'b0, 0);
      applyStimulus(6, 1'b1, 3);

      // Reset in the middle of MUL for n=7
      bus.start = 1'b1;
      bus.n     = NW'(7);
      @(posedge clk);
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         if (c == 0) bus.start = 1'b0;
      end
      checkOutput("midop busy", 64'(bus.busy), 64'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midreset busy", 64'(bus.busy), 64'd0);
      checkOutput("midreset done", 64'(bus.done), 64'd0);
      checkOutput("midreset result", 64'(bus.result), 64'd0);
      checkOutput("midreset ovf", 64'(bus.ovf), 64'd0);
      checkOutput("midreset add_a", 64'(bus.add_a), 64'd0);
      checkOutput("midreset add_b", 64'(bus.add_b), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      applyStimulus(4, 1'b0, 0);

      for (int t = 0; t < 20; t++) begin
         applyStimulus(int'($urandom_range(0, 31)), 1'(($urandom % 4) == 0), int'($urandom_range(0, 31)));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/fact_seq.md
# fact_seq

Iterative factorial sequencer for the factorial machine. It computes n! by repeated shift-and-add multiplication and time-shares one external 32-bit carry-lookahead adder for every partial-product addition. It sits between the top-level start/result handshake and the 32-bit adder instance. It owns all sequencing, overflow detection and result holding.

## Interface
- NW, default 5: width of operand n and of the factor counter; also the number of MUL cycles per factor.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- n  in  NW  operand, sampled with accepted start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; result/ovf valid from this cycle on
- result  out  32  n! mod 2^32 (see Configuration)
- ovf  out  1  true product exceeded 32 bits
- add_a  out  32  adder operand A
- add_b  out  32  adder operand B
- add_ci  out  1  adder carry-in, always 0
- add_s  in  32  adder sum, combinational from add_a/add_b same cycle
- add_co  in  1  adder carry-out, same cycle

## Operation
- Internal registers: nreg (NW), k (NW), acc (32), prod (32), mcand (32), mplr (NW), bitcnt, ovf_acc (sticky).
- States: IDLE, LOAD, MUL, NEXT, DONE.
- IDLE + start:
  - nreg=n, acc=1, k=2, ovf_acc=0.
  - If n<=1, go to DONE; otherwise go to LOAD.
- IDLE without start: hold.
- LOAD: prod=0, mcand=acc, mplr=k, bitcnt=0; go to MUL.
- MUL (exactly NW cycles):
  - Drive add_a=prod, add_b=mcand.
  - If mplr[0]: prod<=add_s and ovf_acc|=add_co.
  - If mcand[31] and mplr[NW-1:1]!=0: ovf_acc<=1.
  - mcand<=mcand<<1, mplr<=mplr>>1, bitcnt++.
  - After the cycle with bitcnt==NW-1, go to NEXT.
- NEXT: acc<=prod; if k==nreg go to DONE, else k<=k+1 and go to LOAD.
- DONE:
  - done=1, result<=final value, ovf<=ovf_acc.
  - Go to IDLE.
- Outside MUL: add_a=0, add_b=0. add_ci=0 at all times.
- start while busy is ignored, not queued.
- n is used only at acceptance; later changes to n have no effect.
- result/ovf hold their value until the next DONE.
- Reset, including mid-operation: state=IDLE; busy, done, ovf, result, add_a, add_b all 0. The next start after reset deasserts runs normally.

## Timing
- Accepting edge is E0, where start is sampled in IDLE.
- busy rises after E0 and falls after the DONE cycle.
- done is high for exactly one cycle, following edge E0+1 for n<=1 and E0+1+(n-1)(NW+2) for n>=2.
- Per factor: LOAD 1 + MUL NW + NEXT 1 cycles.
- A new start is accepted in the cycle after DONE at the earliest.
- Adder path is single-cycle combinational: add_s/add_co must settle within one clk period of add_a/add_b.

## Configuration
- FACT_OVF_SAT_EN:
  - Defined: when ovf_acc=1 at DONE, result=32'hFFFF_FFFF.
  - Undefined: result = n! mod 2^32.
  - ovf behaves identically in both builds.

## Test plan
- Reset, then start with n=5 (NW=5) -> done at E0+29, result=120 (0x78), ovf=0; busy high E0+1..E0+29.
- n=0, then n=1 -> each done at E0+1, result=1, ovf=0, and adder operands stay 0 throughout.
- n=12 -> result=0x1C8CFC00, ovf=0.
- n=13 -> ovf=1; result=0x7328CC00 without FACT_OVF_SAT_EN, 0xFFFFFFFF with it.
- Pulse start with n=3 while busy on n=6 -> second start ignored, result=720, single done pulse.
- Assert reset during MUL of n=7 -> all outputs 0 next cycle; a following start with n=4 gives result=24, ovf=0.
